som_weight_update: RTL and testbench
====================================

// Module: som_weight_update
// PURPOSE
//  Downstream of the winner-selection stage in the 8x8 SOM datapath. On start it latches winner_x/y, the input
//  vector, radius and learning rate, then walks all 64 neurons in index order (idx = {y,x}, same as the
//  winner bus). Each neuron within Manhattan grid distance <= radius gets w <= w + ((x - w) >>> lr_shift),
//  done as a read-modify-write on the shared weight memory. Ends with a one-cycle done pulse.
// PARAMETERS
//  DIM  4  vector components per neuron
//  WW   8  bits per component, unsigned
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       request an update pass; sampled only in IDLE
//  winner_x   in   3       winner column from the winner-selection stage
//  winner_y   in   3       winner row
//  in_vec     in   DIM*WW  training vector, component 0 in LSBs
//  radius     in   4       neighbourhood radius 0..14 (Manhattan distance on the grid)
//  lr_shift   in   3       learning rate = 2^-lr_shift
//  mem_addr   out  6       weight memory neuron address {y,x}
//  mem_rd_en  out  1       read strobe; mem_rdata is valid exactly 1 cycle later
//  mem_rdata  in   DIM*WW  weight read data
//  mem_we     out  1       write strobe
//  mem_wdata  out  DIM*WW  updated weight
//  busy       out  1       high from the cycle after start is accepted through the DONE cycle
//  done       out  1       one-cycle pulse when the pass completes
//  upd_count  out  7       number of neurons written in the last pass; stable from done until next start
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; idx 0; latched operands 0.
//  FSM states:
//   IDLE: if start=1, latch winner_x/y, in_vec, radius, lr_shift; clear idx and upd_count; go to SCAN.
//         start is ignored in every other state and does not re-latch operands.
//   SCAN: d = |idx[2:0]-wx| + |idx[5:3]-wy| (4-bit, unsigned).
//         If d <= radius: mem_rd_en=1, mem_addr=idx, go to RD.
//         Else: if idx==63 go to DONE, otherwise idx+1 and stay in SCAN.
//   RD:   wait state; memory returns the data.
//   WB:   mem_we=1, mem_addr=idx, mem_wdata=updated weight; upd_count+1;
//         then go to DONE if idx==63, otherwise idx+1 and go to SCAN.
//   DONE: done=1 for this cycle only; busy=1; next state IDLE.
//  Timing: each out-of-range neuron takes 1 cycle; each in-range neuron takes 3 cycles (SCAN, RD, WB).
//   With start sampled in cycle T and N updated neurons, done is high in cycle T+65+2N.
//  Per-component arithmetic:
//   diff = $signed({1'b0,x}) - $signed({1'b0,w}), WW+1 bits.
//   step = diff >>> lr_shift (arithmetic shift, floors toward -inf).
//   new  = w + step, truncated to WW bits.
//   The result always lies between w and x inclusive, so no saturation is needed.
//   lr_shift=0 gives new=x; lr_shift >= WW+1 gives step in {0,-1}.
//  Boundaries:
//   - radius >= 14 updates all 64 neurons; radius 0 updates only the winner.
//   - idx does not wrap: the pass ends after idx 63.
//   - mem_rd_en and mem_we are never high in the same cycle.
//   - mem_addr is don't-care when both strobes are low, but is driven to 0 in IDLE.
//   - rst_n low mid-pass: immediately return to IDLE with all strobes low; a partially written pass is
//     not resumed; the next start begins a new pass at idx 0.
// STRUCTURE
//  Package som_pkg:
//   - constants GRID_BITS=3, NEURONS=64, MEM_RD_LAT=1
//   - state enum {IDLE, SCAN, RD, WB, DONE}
//   - grid-distance function (shared with the distance and winner stages)
//  Sub-module som_vec_lerp (combinational, DIM lanes of the per-component update above).
//  Instantiated once; it is also reused by the batch-update variant.
// TESTING
//  1. winner (3,2), radius 0, lr_shift 1, w[26]=8'h40 all components, x=8'h80
//     -> only addr 26 written, data 8'h60 per component; upd_count=1; done in cycle T+67.
//  2. radius 14, lr_shift 0 -> all 64 addresses written in order 0..63 with data x;
//     upd_count=64; done in cycle T+193.
//  3. winner (0,0), radius 1 -> writes only at idx 0, 1, 8; upd_count=3; done in cycle T+71.
//  4. w=8'h05, x=8'h00, lr_shift 3 -> step = -1 (floor), wdata 8'h04;
//     w=8'hFF, x=8'h00, lr_shift 0 -> wdata 8'h00.
//  5. start pulsed again while busy, with different winner
//     -> ignored; writes match the first operands; done pulses once.
//  6. rst_n asserted during the RD state of idx 10 -> strobes drop at once, busy=0, upd_count=0;
//     a new start after release rescans from idx 0.

Source files
------------

// File: rtl/som_pkg.sv
// Shared constants, FSM state type and grid-distance helper for the 8x8 SOM datapath.
package som_pkg;

  localparam int GRID_BITS  = 3;
  localparam int NEURONS    = 64;
  localparam int MEM_RD_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    RD,
    WB,
    DONE
  } state_t;

  // Manhattan distance between two grid coordinates; max 7+7=14 fits in 4 bits
  function automatic logic [3:0] grid_dist(input logic [GRID_BITS-1:0] ax,
                                           input logic [GRID_BITS-1:0] ay,
                                           input logic [GRID_BITS-1:0] bx,
                                           input logic [GRID_BITS-1:0] by);
    logic [GRID_BITS-1:0] dx;
    logic [GRID_BITS-1:0] dy;
    dx = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy = (ay >= by) ? (ay - by) : (by - ay);
    return {1'b0, dx} + {1'b0, dy};
  endfunction

endpackage

// File: rtl/som_vec_lerp.sv
// Combinational per-component weight update: w + ((x - w) >>> lr_shift), DIM lanes.
module som_vec_lerp #(
  parameter int DIM = 4,
  parameter int WW  = 8
) (
  input  logic [DIM*WW-1:0] in_vec,
  input  logic [DIM*WW-1:0] w_vec,
  input  logic [2:0]        lr_shift,
  output logic [DIM*WW-1:0] new_vec
);

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic signed [WW:0] diff;
    logic signed [WW:0] step;

    // The floored step keeps the result between w and x, so truncation never overflows
    assign diff = $signed({1'b0, in_vec[i*WW +: WW]}) - $signed({1'b0, w_vec[i*WW +: WW]});
    assign step = diff >>> lr_shift;
    assign new_vec[i*WW +: WW] = w_vec[i*WW +: WW] + step[WW-1:0];
  end

endmodule

// File: rtl/som_weight_update.sv
// Neighbourhood weight update: scans all 64 neurons and read-modify-writes those within radius of the winner.
module som_weight_update
  import som_pkg::*;
#(
  parameter int DIM = 4,
  parameter int WW  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [GRID_BITS-1:0] winner_x,
  input  logic [GRID_BITS-1:0] winner_y,
  input  logic [DIM*WW-1:0]    in_vec,
  input  logic [3:0]           radius,
  input  logic [2:0]           lr_shift,
  output logic [5:0]           mem_addr,
  output logic                 mem_rd_en,
  input  logic [DIM*WW-1:0]    mem_rdata,
  output logic                 mem_we,
  output logic [DIM*WW-1:0]    mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic [6:0]           upd_count
);

  state_t               state;
  state_t               next_state;
  logic [5:0]           idx;
  logic                 idx_adv;
  logic [GRID_BITS-1:0] wx_q;
  logic [GRID_BITS-1:0] wy_q;
  logic [DIM*WW-1:0]    x_q;
  logic [DIM*WW-1:0]    w_q;
  logic [3:0]           radius_q;
  logic [2:0]           lr_q;
  logic [DIM*WW-1:0]    new_w;
  logic                 in_range;
  logic                 last_idx;

  assign in_range = grid_dist(idx[2:0], idx[5:3], wx_q, wy_q) <= radius_q;
  assign last_idx = (idx == 6'(NEURONS - 1));

  som_vec_lerp #(
    .DIM (DIM),
    .WW  (WW)
  ) u_lerp (
    .in_vec   (x_q),
    .w_vec    (w_q),
    .lr_shift (lr_q),
    .new_vec  (new_w)
  );

  // Operands are latched only on an accepted start so a pass always sees one consistent set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      wx_q      <= '0;
      wy_q      <= '0;
      x_q       <= '0;
      w_q       <= '0;
      radius_q  <= '0;
      lr_q      <= '0;
      upd_count <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        wx_q      <= winner_x;
        wy_q      <= winner_y;
        x_q       <= in_vec;
        radius_q  <= radius;
        lr_q      <= lr_shift;
        idx       <= '0;
        upd_count <= '0;
      end
      if (idx_adv) begin
        idx <= idx + 6'd1;
      end
      // Read data is only guaranteed valid for the single cycle after the strobe
      if (state == RD) begin
        w_q <= mem_rdata;
      end
      if (state == WB) begin
        upd_count <= upd_count + 7'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    idx_adv    = 1'b0;
    mem_addr   = '0;
    mem_rd_en  = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          next_state = SCAN;
        end
      end
      SCAN: begin
        if (in_range) begin
          mem_rd_en  = 1'b1;
          mem_addr   = idx;
          next_state = RD;
        end else if (last_idx) begin
          next_state = DONE;
        end else begin
          idx_adv = 1'b1;
        end
      end
      RD: begin
        next_state = WB;
      end
      WB: begin
        mem_we    = 1'b1;
        mem_addr  = idx;
        mem_wdata = new_w;
        if (last_idx) begin
          next_state = DONE;
        end else begin
          idx_adv    = 1'b1;
          next_state = SCAN;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_som_weight_update.sv
// Directed self-checking bench for som_weight_update with a one-cycle-latency weight memory model.
module tb_som_weight_update;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  winner_x;
  logic [2:0]  winner_y;
  logic [31:0] in_vec;
  logic [3:0]  radius;
  logic [2:0]  lr_shift;
  logic [5:0]  mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [6:0]  upd_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int lat;
  int done_cnt = 0;
  int overlap = 0;
  int good;
  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] mem[64];

  som_weight_update #(.DIM(4), .WW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .winner_x  (winner_x),
    .winner_y  (winner_y),
    .in_vec    (in_vec),
    .radius    (radius),
    .lr_shift  (lr_shift),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .upd_count (upd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory: read data appears exactly one cycle after the strobe
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (mem_we && mem_rd_en) overlap++;
    if (done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic fillMem(input logic [31:0] v);
    for (int i = 0; i < 64; i++) mem[i] <= v;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [2:0] wx, input logic [2:0] wy, input logic [31:0] x,
                               input logic [3:0] rad, input logic [2:0] lr);
    @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    winner_x = wx;
    winner_y = wy;
    in_vec   = x;
    radius   = rad;
    lr_shift = lr;
    start    = 1'b1;
    t0       = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int latency);
    latency = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (done) begin
        latency = cyc - t0;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    winner_x = '0;
    winner_y = '0;
    in_vec = '0;
    radius = '0;
    lr_shift = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_strobes", 64'({mem_rd_en, mem_we}), 64'd0);
    checkOutput("reset_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("reset_upd_count", 64'(upd_count), 64'd0);
    rst_n = 1'b1;

    $display("[TB] test 1: radius 0 winner x=2 y=3");
    fillMem(32'h40404040);
    applyStimulus(3'd2, 3'd3, 32'h80808080, 4'd0, 3'd1);
    #1;
    checkOutput("t1_busy", 64'(busy), 64'd1);
    waitDone(300, lat);
    checkOutput("t1_latency", 64'(lat), 64'd67);
    checkOutput("t1_nwrites", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() == 1) begin
      checkOutput("t1_addr", 64'(wr_addr[0]), 64'd26);
      checkOutput("t1_data", 64'(wr_data[0]), 64'h60606060);
    end
    checkOutput("t1_upd_count", 64'(upd_count), 64'd1);

    $display("[TB] test 2: radius 14 lr 0");
    fillMem(32'h40404040);
    applyStimulus(3'd0, 3'd0, 32'hA1B2C3D4, 4'd14, 3'd0);
    waitDone(400, lat);
    checkOutput("t2_latency", 64'(lat), 64'd193);
    checkOutput("t2_nwrites", 64'(wr_addr.size()), 64'd64);
    good = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] == 6'(i) && wr_data[i] == 32'hA1B2C3D4) good++;
    checkOutput("t2_ordered_writes", 64'(good), 64'd64);
    checkOutput("t2_upd_count", 64'(upd_count), 64'd64);

    $display("[TB] test 3: corner winner radius 1");
    applyStimulus(3'd0, 3'd0, 32'h11111111, 4'd1, 3'd2);
    waitDone(300, lat);
    checkOutput("t3_latency", 64'(lat), 64'd71);
    checkOutput("t3_nwrites", 64'(wr_addr.size()), 64'd3);
    if (wr_addr.size() == 3)
      checkOutput("t3_addrs", 64'({wr_addr[0], wr_addr[1], wr_addr[2]}), 64'({6'd0, 6'd1, 6'd8}));
    checkOutput("t3_upd_count", 64'(upd_count), 64'd3);

    $display("[TB] test 4: arithmetic boundaries");
    fillMem(32'h05050505);
    applyStimulus(3'd0, 3'd0, 32'h00000000, 4'd0, 3'd3);
    waitDone(300, lat);
    checkOutput("t4a_data", 64'(wr_data.size() > 0 ? wr_data[0] : 32'hx), 64'h04040404);
    fillMem(32'hFFFFFFFF);
    applyStimulus(3'd0, 3'd0, 32'h00000000, 4'd0, 3'd0);
    waitDone(300, lat);
    checkOutput("t4b_data", 64'(wr_data.size() > 0 ? wr_data[0] : 32'hx), 64'h00000000);
    fillMem(32'h1080FF00);
    applyStimulus(3'd0, 3'd0, 32'h118000FF, 4'd0, 3'd7);
    waitDone(300, lat);
    checkOutput("t4c_data_lr7", 64'(wr_data.size() > 0 ? wr_data[0] : 32'hx), 64'h1080FD01);

    $display("[TB] test 5: start while busy");
    fillMem(32'h40404040);
    applyStimulus(3'd2, 3'd3, 32'h80808080, 4'd0, 3'd1);
    repeat (4) @(negedge clk);
    winner_x = 3'd5;
    winner_y = 3'd5;
    in_vec   = 32'h00000000;
    radius   = 4'd14;
    lr_shift = 3'd0;
    start    = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    waitDone(300, lat);
    checkOutput("t5_latency", 64'(lat), 64'd67);
    checkOutput("t5_nwrites", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() == 1)
      checkOutput("t5_write", 64'({wr_addr[0], wr_data[0]}), 64'({6'd26, 32'h60606060}));
    repeat (3) @(negedge clk);
    checkOutput("t5_done_pulses", 64'(done_cnt), 64'd1);
    checkOutput("t5_upd_count_stable", 64'(upd_count), 64'd1);

    $display("[TB] test 6: reset during RD of idx 10");
    fillMem(32'h40404040);
    applyStimulus(3'd2, 3'd1, 32'h80808080, 4'd0, 3'd1);
    good = 0;
    for (int n = 0; n < 40; n++) begin
      if (mem_rd_en && mem_addr == 6'd10) begin
        good = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t6_read_idx10", 64'(good), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_strobes", 64'({mem_rd_en, mem_we}), 64'd0);
    checkOutput("t6_busy", 64'(busy), 64'd0);
    checkOutput("t6_upd_count", 64'(upd_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("t6_no_write", 64'(wr_addr.size()), 64'd0);
    applyStimulus(3'd0, 3'd0, 32'h80808080, 4'd0, 3'd1);
    waitDone(300, lat);
    checkOutput("t6_rescan_latency", 64'(lat), 64'd67);
    checkOutput("t6_rescan_addr", 64'(wr_addr.size() > 0 ? wr_addr[0] : 6'h3F), 64'd0);

    checkOutput("strobe_overlap", 64'(overlap), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
